// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin grant scheduler for an 8:1 data mux.
//
// Eight requesters compete for one mux. The winner holds the mux until it signals
// done, drops its request, or has used MAX_BURST consecutive cycles. The next
// winner is then chosen in the same edge, so there is no idle bubble. The search
// starts one past the last grantee, which means the last grantee is searched last.
//
// Ports:
//   clk   - clock; all state updates happen on the rising edge
//   rst_n - asynchronous active-low reset
//   req   - [7:0] request per mux input; bit i requests D(i)
//   done  - current grantee has finished; releases the grant at this edge
//   gnt   - [7:0] registered one-hot grant; all-zero when idle
//   sel   - [2:0] registered mux select (s2..s0); equals the index of gnt
//   valid - high while a grant is held; mux output Y belongs to the grantee
//
// Parameters:
//   MAX_BURST - maximum consecutive grant cycles per holder (1..8)
//
// Build option:
//   MUX_SCHED_PARK_EN - when defined, sel stays parked on the last grantee while
//                       idle; otherwise sel returns to 0 on entering idle.
module mux_rr_scheduler #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       valid
);

    localparam logic [2:0] BURST_LAST = 3'(MAX_BURST - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] cnt_q, cnt_d;

    logic       release_now;
    logic [3:0] pick;
    logic [2:0] search_from;

    // Returns {found, index} of the first set bit of r, searching from last+1
    // upward with wrap, so index last is examined last.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = last + 3'(i) + 3'd1;
            if (!res[3] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign release_now = done || !req[sel_q] || (cnt_q == BURST_LAST);

    // In idle search past the pointer; on release search past the grantee, which
    // becomes the new pointer in the same edge.
    assign search_from = (state_q == StGrant) ? sel_q : ptr_q;

    // A grantee that dropped its request already has a clear bit in req, so the
    // raw request vector serves as the masked one.
    assign pick = rr_pick(req, search_from);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                // done is meaningless without a grantee and is ignored here
                if (pick[3]) begin
                    state_d = StGrant;
                    gnt_d   = 8'b1 << pick[2:0];
                    sel_d   = pick[2:0];
                    cnt_d   = 3'd0;
                end
            end
            StGrant: begin
                if (release_now) begin
                    ptr_d = sel_q;
                    if (pick[3]) begin
                        gnt_d = 8'b1 << pick[2:0];
                        sel_d = pick[2:0];
                        cnt_d = 3'd0;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = 8'h00;
                        cnt_d   = 3'd0;
`ifdef MUX_SCHED_PARK_EN
                        sel_d   = sel_q;
`else
                        sel_d   = 3'd0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 8'h00;
                sel_d   = 3'd0;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= 8'h00;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd7;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = (state_q == StGrant);

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed testbench for mux_rr_scheduler with MAX_BURST = 4.
module tb_mux_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;

    int n_tests = 0;
    int n_fail  = 0;

    mux_rr_scheduler #(
        .MAX_BURST(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .done (done),
        .gnt  (gnt),
        .sel  (sel),
        .valid(valid)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges and release it away from the rising edge.
    task automatic do_reset();
        req  = 8'h00;
        done = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({gnt, sel, valid} !== {8'h00, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: gnt=%h sel=%0d valid=%b, required 00/0/0", gnt, sel, valid);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        req   = 8'h00;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++;
            if ({gnt, sel, valid} !== {8'h00, 3'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL idle_no_req[%0d]: gnt=%h sel=%0d valid=%b, required 00/0/0",
                         k, gnt, sel, valid);
            end
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp_gnt;
        logic [2:0] exp_sel;
        do_reset();
        req = 8'h81;
        for (int k = 0; k < 16; k++) begin
            tick();
            exp_gnt = (((k / 4) % 2) == 0) ? 8'h01 : 8'h80;
            exp_sel = (((k / 4) % 2) == 0) ? 3'd0 : 3'd7;
            n_tests++;
            if ({gnt, sel, valid} !== {exp_gnt, exp_sel, 1'b1}) begin
                n_fail++;
                $display("FAIL burst[%0d]: gnt=%h sel=%0d valid=%b, required %h/%0d/1",
                         k, gnt, sel, valid, exp_gnt, exp_sel);
            end
        end
    endtask

    task automatic test_rotate_done();
        logic [7:0] exp_gnt;
        do_reset();
        req  = 8'hFF;
        done = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp_gnt = 8'h01 << (k % 8);
            n_tests++;
            if ({gnt, sel, valid} !== {exp_gnt, 3'(k % 8), 1'b1}) begin
                n_fail++;
                $display("FAIL rotate[%0d]: gnt=%h sel=%0d valid=%b, required %h/%0d/1",
                         k, gnt, sel, valid, exp_gnt, k % 8);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        req = 8'h40;
        tick();
        n_tests++;
        if ({gnt, sel, valid} !== {8'h40, 3'd6, 1'b1}) begin
            n_fail++;
            $display("FAIL prio_first: gnt=%h sel=%0d valid=%b, required 40/6/1", gnt, sel, valid);
        end
        req  = 8'h41;
        done = 1'b1;
        tick();
        n_tests++;
        if ({gnt, sel, valid} !== {8'h01, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL prio_wrap: gnt=%h sel=%0d valid=%b, required 01/0/1", gnt, sel, valid);
        end
        // Non-granted bits change while bit 0 holds the grant.
        done = 1'b0;
        req  = 8'h03;
        tick();
        n_tests++;
        if ({gnt, sel, valid} !== {8'h01, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL prio_hold: gnt=%h sel=%0d valid=%b, required 01/0/1", gnt, sel, valid);
        end
        req  = 8'h41;
        done = 1'b1;
        tick();
        n_tests++;
        if ({gnt, sel, valid} !== {8'h40, 3'd6, 1'b1}) begin
            n_fail++;
            $display("FAIL prio_back: gnt=%h sel=%0d valid=%b, required 40/6/1", gnt, sel, valid);
        end
        done = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h10;
        tick();
        n_tests++;
        if ({gnt, sel, valid} !== {8'h10, 3'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_pre: gnt=%h sel=%0d valid=%b, required 10/4/1", gnt, sel, valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({gnt, sel, valid} !== {8'h00, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_abort: gnt=%h sel=%0d valid=%b, required 00/0/0", gnt, sel, valid);
        end
        req = 8'h0C;
        #1;
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({gnt, sel, valid} !== {8'h04, 3'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_regrant: gnt=%h sel=%0d valid=%b, required 04/2/1", gnt, sel, valid);
        end
    endtask

    task automatic test_park();
        logic [2:0] exp_sel;
`ifdef MUX_SCHED_PARK_EN
        exp_sel = 3'd5;
`else
        exp_sel = 3'd0;
`endif
        do_reset();
        req = 8'h20;
        tick();
        n_tests++;
        if ({gnt, sel, valid} !== {8'h20, 3'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL park_grant: gnt=%h sel=%0d valid=%b, required 20/5/1", gnt, sel, valid);
        end
        req = 8'h00;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_tests++;
            if ({gnt, sel, valid} !== {8'h00, exp_sel, 1'b0}) begin
                n_fail++;
                $display("FAIL park_idle[%0d]: gnt=%h sel=%0d valid=%b, required 00/%0d/0",
                         k, gnt, sel, valid, exp_sel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_rotate_done();
        test_priority();
        test_reset_mid();
        test_park();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
